mux_arb: RTL and testbench

Registered N-channel, parametrised successor to the fixed 4-to-1 key multiplexer. It selects one of NR_CH valid/ready input channels of DATA_LEN bits and presents the chosen word on a single registered valid/ready output, tagged with its channel index. Two modes are supported: fixed select, where an external key picks the channel, and round-robin arbitration among valid channels. It sits between multiple producers and one shared consumer, such as a display or bus port.

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/mux_arb_rr_pick.sv | 29 ++
 rtl/mux_arb.sv | 104 ++++++++++
 tb/tb_mux_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants for the registered N-channel multiplexer/arbiter.
// Mode encodings and output-stage state encodings live here.
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational rotating-priority picker: grants the first requester at or after ptr,
// wrapping explicitly at NR_CH so non-power-of-two channel counts behave.
module rr_pick #(
  parameter int NR_CH   = 4,
  parameter int SEL_LEN = $clog2(NR_CH)
) (
  input  logic [NR_CH-1:0]   req,
  input  logic [SEL_LEN-1:0] ptr,
  output logic               gnt_valid,
  output logic [SEL_LEN-1:0] gnt_idx
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path infers a latch.
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NR_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NR_CH) idx = idx - NR_CH;
      if (!gnt_valid && idx < NR_CH && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_LEN'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Registered N-channel valid/ready multiplexer with fixed-select and round-robin modes.
// A single output register refills in the same cycle it drains.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 2,
  parameter int SEL_LEN  = $clog2(NR_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_LEN-1:0]        sel,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [SEL_LEN-1:0]        out_ch
);

  state_e                state_q, state_d;
  logic [DATA_LEN-1:0]   data_q, data_d;
  logic [SEL_LEN-1:0]    ch_q, ch_d;
  logic [SEL_LEN-1:0]    ptr_q, ptr_d;

  logic                  rr_valid;
  logic [SEL_LEN-1:0]    rr_idx;
  logic                  fix_valid;
  logic                  grant_valid;
  logic [SEL_LEN-1:0]    grant_idx;
  logic                  load_en;
  logic                  xfer;

  rr_pick #(
    .NR_CH   (NR_CH),
    .SEL_LEN (SEL_LEN)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // An out-of-range key matches no channel, so it simply never grants.
  always_comb begin
    fix_valid = 1'b0;
    for (int n = 0; n < NR_CH; n++) begin
      if (sel == SEL_LEN'(n)) fix_valid = in_valid[n];
    end
  end

  assign grant_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
  assign grant_idx   = (mode == MODE_RR) ? rr_idx   : sel;
  assign load_en     = (state_q == ST_EMPTY) || out_ready;
  assign xfer        = !rst && load_en && grant_valid;

  always_comb begin
    in_ready = '0;
    for (int n = 0; n < NR_CH; n++) begin
      in_ready[n] = xfer && (grant_idx == SEL_LEN'(n));
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      state_d = ST_FULL;
      ch_d    = grant_idx;
      for (int n = 0; n < NR_CH; n++) begin
        if (grant_idx == SEL_LEN'(n)) data_d = in_data[n*DATA_LEN +: DATA_LEN];
      end
      if (mode == MODE_RR) begin
        ptr_d = (grant_idx == SEL_LEN'(NR_CH - 1)) ? '0 : grant_idx + SEL_LEN'(1);
      end
    end else if (state_q == ST_FULL && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: a 4-channel and a 3-channel instance checked every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_mux_arb;

  typedef struct {
    bit full;
    int data;
    int ch;
    int ptr;
  } mst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       mode4 = 1'b1, ordy4 = 1'b1;
  logic [1:0] sel4 = '0;
  logic [3:0] valid4 = 4'b1111, rdy4;
  logic [7:0] data4 = 8'b11100100;
  logic       ovalid4;
  logic [1:0] odata4, och4;

  logic       mode3 = 1'b1, ordy3 = 1'b1;
  logic [1:0] sel3 = '0;
  logic [2:0] valid3 = 3'b111, rdy3;
  logic [5:0] data3 = 6'b100100;
  logic       ovalid3;
  logic [1:0] odata3, och3;

  int n_cmp = 0;
  int n_bad = 0;

  mst_t m4, m3;
  bit   k4 = 0, k3 = 0;

  mux_arb #(.NR_CH(4), .DATA_LEN(2)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
    .in_valid(valid4), .in_ready(rdy4), .in_data(data4),
    .out_valid(ovalid4), .out_ready(ordy4), .out_data(odata4), .out_ch(och4)
  );

  mux_arb #(.NR_CH(3), .DATA_LEN(2)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_valid(valid3), .in_ready(rdy3), .in_data(data3),
    .out_valid(ovalid3), .out_ready(ordy3), .out_data(odata3), .out_ch(och3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: search order by modular arithmetic, one register slot.
  function automatic void mstep(input int n, input mst_t s, input bit r, input bit md,
                                input int sl, input logic [3:0] v, input logic [7:0] d,
                                input bit ordy, output logic [3:0] rdy, output mst_t ns);
    bit gv;
    int g;
    int c;
    ns  = s;
    rdy = '0;
    gv  = 0;
    g   = 0;
    if (r) begin
      ns.full = 0; ns.data = 0; ns.ch = 0; ns.ptr = 0;
    end else begin
      if (md) begin
        for (int k = 0; k < n; k++) begin
          c = (s.ptr + k) % n;
          if (!gv && v[c]) begin gv = 1; g = c; end
        end
      end else if (sl < n && v[sl]) begin
        gv = 1; g = sl;
      end
      if ((!s.full || ordy) && gv) begin
        rdy[g]  = 1'b1;
        ns.full = 1;
        ns.data = int'((d >> (2 * g)) & 8'd3);
        ns.ch   = g;
        if (md) ns.ptr = (g + 1) % n;
      end else if (s.full && ordy) begin
        ns.full = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [3:0] r4, r3;
    mst_t ns;
    mstep(4, m4, rst, mode4, int'(sel4), valid4, data4, ordy4, r4, ns);
    if (k4) begin
      check("m4_out_valid", 32'(ovalid4), 32'(m4.full));
      if (m4.full) begin
        check("m4_out_data", 32'(odata4), 32'(m4.data));
        check("m4_out_ch", 32'(och4), 32'(m4.ch));
      end
    end
    if (k4 || rst) check("m4_in_ready", 32'(rdy4), 32'(r4));
    m4 = ns;
    if (rst) k4 = 1;

    mstep(3, m3, rst, mode3, int'(sel3), {1'b0, valid3}, {2'b00, data3}, ordy3, r3, ns);
    if (k3) begin
      check("m3_out_valid", 32'(ovalid3), 32'(m3.full));
      if (m3.full) begin
        check("m3_out_data", 32'(odata3), 32'(m3.data));
        check("m3_out_ch", 32'(och3), 32'(m3.ch));
      end
    end
    if (k3 || rst) check("m3_in_ready", 32'({1'b0, rdy3}), 32'(r3));
    m3 = ns;
    if (rst) k3 = 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    int e4 [6];
    int e3 [6];
    e4 = '{0, 1, 2, 3, 0, 1};
    e3 = '{0, 1, 2, 0, 1, 2};

    // Reset with every channel valid: nothing may be readied.
    at_neg();
    check("rst_in_ready4", 32'(rdy4), 32'h0);
    check("rst_in_ready3", 32'(rdy3), 32'h0);
    cyc();
    rst = 1'b0; valid4 = '0; valid3 = '0;
    at_neg();
    check("rst_out_valid4", 32'(ovalid4), 32'h0);
    check("rst_out_data4", 32'(odata4), 32'h0);
    check("rst_out_ch4", 32'(och4), 32'h0);
    check("rst_out_valid3", 32'(ovalid3), 32'h0);

    // Fixed select of channel 2.
    cyc();
    mode4 = 1'b0; sel4 = 2'd2; valid4 = 4'b1111; ordy4 = 1'b1;
    at_neg();
    check("fix_first_ready", 32'(rdy4), 32'h4);
    check("fix_first_empty", 32'(ovalid4), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      at_neg();
      check("fix_valid", 32'(ovalid4), 32'h1);
      check("fix_data", 32'(odata4), 32'h2);
      check("fix_ch", 32'(och4), 32'h2);
      check("fix_ready", 32'(rdy4), 32'h4);
    end

    // Round-robin fairness on both instances.
    cyc();
    mode4 = 1'b1; mode3 = 1'b1; valid3 = 3'b111; ordy3 = 1'b1;
    at_neg();
    check("rr_first_ready4", 32'(rdy4), 32'h1);
    check("rr_first_ready3", 32'(rdy3), 32'h1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      at_neg();
      check("rr_seq_ch4", 32'(och4), 32'(e4[i]));
      check("rr_seq_data4", 32'(odata4), 32'(e4[i]));
      check("rr_seq_ch3", 32'(och3), 32'(e3[i]));
    end

    // Mid-operation reset, then skip over idle channels.
    cyc();
    rst = 1'b1; valid3 = '0;
    at_neg();
    check("rst2_in_ready4", 32'(rdy4), 32'h0);
    cyc();
    rst = 1'b0; valid4 = 4'b1010;
    at_neg();
    check("rst2_discard", 32'(ovalid4), 32'h0);
    check("skip_ready_1", 32'(rdy4), 32'h2);
    cyc();
    at_neg();
    check("skip_ch_1", 32'(och4), 32'h1);
    check("skip_ready_3", 32'(rdy4), 32'h8);
    cyc();
    at_neg();
    check("skip_ch_3", 32'(och4), 32'h3);
    check("skip_data_3", 32'(odata4), 32'h3);

    // Backpressure: word ch1 held for 5 cycles, then drain-and-refill.
    cyc();
    ordy4 = 1'b0; valid4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      at_neg();
      check("bp_valid", 32'(ovalid4), 32'h1);
      check("bp_ch", 32'(och4), 32'h1);
      check("bp_data", 32'(odata4), 32'h1);
      check("bp_ready", 32'(rdy4), 32'h0);
    end
    cyc();
    ordy4 = 1'b1;
    at_neg();
    check("bp_release_ready", 32'(rdy4), 32'h4);
    cyc();
    at_neg();
    check("bp_refill_ch", 32'(och4), 32'h2);
    cyc();
    at_neg();
    check("wrap_ch_3", 32'(och4), 32'h3);
    cyc();
    at_neg();
    check("wrap_ch_0", 32'(och4), 32'h0);

    // Mode switch while FULL; out-of-range key on the 3-channel instance.
    cyc();
    ordy4 = 1'b0; mode4 = 1'b0; sel4 = 2'd3;
    mode3 = 1'b0; sel3 = 2'd2; valid3 = 3'b111; ordy3 = 1'b0;
    at_neg();
    check("msw_ch_hold", 32'(och4), 32'h1);
    check("msw_data_hold", 32'(odata4), 32'h1);
    check("msw_ready", 32'(rdy4), 32'h0);
    check("oor_pre_ready3", 32'(rdy3), 32'h4);
    cyc();
    sel3 = 2'd3; ordy3 = 1'b1;
    at_neg();
    check("msw_ch_hold2", 32'(och4), 32'h1);
    check("oor_full3", 32'(ovalid3), 32'h1);
    check("oor_ch3", 32'(och3), 32'h2);
    check("oor_ready3", 32'(rdy3), 32'h0);
    cyc();
    ordy4 = 1'b1;
    at_neg();
    check("msw_fixed_ready", 32'(rdy4), 32'h8);
    check("oor_drained3", 32'(ovalid3), 32'h0);
    cyc();
    at_neg();
    check("msw_fixed_ch", 32'(och4), 32'h3);
    check("msw_fixed_data", 32'(odata4), 32'h3);
    check("oor_stay_empty3", 32'(ovalid3), 32'h0);

    // Randomized traffic, continuously checked by the model.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst    = ($urandom_range(63) == 0);
      mode4  = 1'($urandom_range(1));
      sel4   = 2'($urandom_range(3));
      valid4 = 4'($urandom);
      data4  = 8'($urandom);
      ordy4  = ($urandom_range(3) != 0);
      mode3  = 1'($urandom_range(1));
      sel3   = 2'($urandom_range(3));
      valid3 = 3'($urandom);
      data3  = 6'($urandom);
      ordy3  = ($urandom_range(3) != 0);
    end
    cyc();
    at_neg();
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
